mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port 32-bit word-addressed RAM between instruction fetch (I) and
//  load/store (D) ports of the kanade32 core. Sequences each access to the RAM port timing:
//  registered address; read data valid one cycle later; write commits with wren+data one
//  cycle after the address. One access in flight; throughput one access per 2 cycles.
// PARAMETERS
//  ADDR_W      30  word-address width (byte address [31:2])
//  DATA_W      32  data width
//  STARVE_MAX  4   max consecutive D grants while I waits (fixed-priority mode only)
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst_n      in   1       asynchronous active-low reset
//  i_req      in   1       fetch request; hold with i_addr stable until i_ack
//  i_addr     in   ADDR_W  fetch word address
//  i_ack      out  1       1-cycle pulse: i_rdata valid, request done
//  i_rdata    out  DATA_W  fetch data, valid only while i_ack=1
//  d_req      in   1       data request; hold d_we/d_addr/d_wdata stable until d_ack
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data word address
//  d_wdata    in   DATA_W  store data
//  d_ack      out  1       1-cycle pulse: load data valid / store committed
//  d_rdata    out  DATA_W  load data, valid only while d_ack=1 and d_we=0
//  mem_wren   out  1       RAM write enable
//  mem_addr   out  ADDR_W  RAM address
//  mem_data   out  DATA_W  RAM write data
//  mem_q      in   DATA_W  RAM read data (addr registered in RAM)
// BEHAVIOUR
//  Reset: state=IDLE, grant=none, starve_cnt=0, i_ack=d_ack=mem_wren=0, mem_addr=0, mem_data=0.
//  States: IDLE -> (grant) RD_RESP | WR_COMMIT -> IDLE.
//  IDLE: if any req, pick winner, latch gnt; drive mem_addr=winner addr this cycle;
//        next = WR_COMMIT if D granted with d_we=1, else RD_RESP. No req: stay, mem_addr held.
//  RD_RESP: mem_addr held; winner's ack=1, rdata=mem_q (combinational pass-through); -> IDLE.
//  WR_COMMIT: mem_addr held, mem_wren=1, mem_data=d_wdata, d_ack=1; -> IDLE.
//  mem_wren is 1 only in WR_COMMIT; acks only in RD_RESP/WR_COMMIT; never both acks at once.
//  Latency: req seen in IDLE at edge N -> ack during cycle N+1 (2 cycles req-to-ack min).
//  Arbitration (default): D beats I; starve_cnt++ on each D grant while i_req=1, cleared
//    on any I grant or when i_req=0; at starve_cnt==STARVE_MAX I wins next contested grant.
//  Back-to-back: requester may keep req high after ack for the next access; it is
//    re-arbitrated in the following IDLE cycle.
//  Req dropped before ack: protocol violation; access completes, ack still pulses.
//  Reset asserted mid-access: immediate IDLE, mem_wren drops asynchronously, in-flight
//    write is abandoned (not committed), no ack issued.
//  Addresses pass through unmodified; out-of-range handling belongs to the RAM.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin; on contest the port not granted last wins;
//    last-grant flag resets to I (so D wins first contest); starve_cnt/STARVE_MAX unused.
//  Undefined: fixed D-priority with starvation guard as above.
// STRUCTURE
//  Package kanade_mem_pkg: arb_state_t {IDLE, RD_RESP, WR_COMMIT}, grant_t {GNT_NONE,
//    GNT_I, GNT_D}, MEM_ADDR_W/MEM_DATA_W constants shared with core and RAM.
//  Sub-module mem_arb_pick: combinational winner select (i_req, d_req, starve/last-grant)
//    -> grant_t; both policy variants live there under the macro.
// TESTING
//  1 I-only: i_req, i_addr=0x10 -> mem_addr=0x10 at N, i_ack+i_rdata=RAM[0x10] at N+1.
//  2 D store then load: d_we=1,addr=0x20,wdata=0xDEADBEEF -> mem_wren=1 one cycle only,
//    d_ack; then load 0x20 -> d_rdata=0xDEADBEEF.
//  3 Contention, fixed prio: i_req,d_req held high -> 4 D grants then 1 I grant, repeating.
//  4 Contention, MEM_ARB_RR_EN: both held -> grants alternate D,I,D,I; no double acks.
//  5 Reset in WR_COMMIT: rst_n low mid-cycle -> mem_wren=0 immediately, target word unchanged,
//    no d_ack; after release, idle outputs all zero.
//  6 Idle: no req 10 cycles -> acks=0, mem_wren=0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the kanade32 memory arbiter, core and RAM.
package kanade_mem_pkg;

  localparam int MEM_ADDR_W = 30;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_RESP,
    WR_COMMIT
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch (I) and load/store (D) requests.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed D priority with a starvation guard.
module mem_arb_pick
  import kanade_mem_pkg::*;
`ifndef MEM_ARB_RR_EN
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
)
`endif
(
  input  logic             i_req,
  input  logic             d_req,
`ifdef MEM_ARB_RR_EN
  input  grant_t           last_gnt,
`else
  input  logic [CNT_W-1:0] starve_cnt,
`endif
  output grant_t           gnt
);

`ifdef MEM_ARB_RR_EN
  // On a contest the port that did not win last time goes first.
  always_comb begin
    gnt = GNT_NONE;
    if (i_req && d_req) begin
      gnt = (last_gnt == GNT_D) ? GNT_I : GNT_D;
    end else if (d_req) begin
      gnt = GNT_D;
    end else if (i_req) begin
      gnt = GNT_I;
    end
  end
`else
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  // D normally wins; once fetch has lost STARVE_MAX contests in a row it gets one turn.
  always_comb begin
    gnt = GNT_NONE;
    if (i_req && d_req) begin
      gnt = (starve_cnt == STARVE_LIM) ? GNT_I : GNT_D;
    end else if (d_req) begin
      gnt = GNT_D;
    end else if (i_req) begin
      gnt = GNT_I;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, one access per 2 cycles.
// Handshake: a requester holds req and its address/data stable until its 1-cycle ack pulse.
// Optional macro MEM_ARB_RR_EN switches arbitration from fixed D priority to round-robin.
module mem_arbiter
  import kanade_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  output arb_state_t        dbg_state
);

  arb_state_t        state_q, state_nxt;
  grant_t            gnt_q, gnt_nxt;
  grant_t            pick;
  logic [ADDR_W-1:0] addr_q, addr_nxt;

`ifdef MEM_ARB_RR_EN
  grant_t last_gnt;

  mem_arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= GNT_I;
    end else if (state_q == IDLE && pick != GNT_NONE) begin
      last_gnt <= pick;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .gnt        (pick)
  );

  // Counts D wins while fetch is waiting; any fetch grant or idle fetch port clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!i_req) begin
      starve_cnt <= '0;
    end else if (state_q == IDLE && pick == GNT_I) begin
      starve_cnt <= '0;
    end else if (state_q == IDLE && pick == GNT_D && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = gnt_q;
    addr_nxt  = addr_q;
    case (state_q)
      IDLE: begin
        if (pick != GNT_NONE) begin
          gnt_nxt   = pick;
          addr_nxt  = (pick == GNT_D) ? d_addr : i_addr;
          state_nxt = (pick == GNT_D && d_we) ? WR_COMMIT : RD_RESP;
        end
      end
      RD_RESP, WR_COMMIT: begin
        state_nxt = IDLE;
        gnt_nxt   = GNT_NONE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= GNT_NONE;
      addr_q  <= '0;
    end else begin
      state_q <= state_nxt;
      gnt_q   <= gnt_nxt;
      addr_q  <= addr_nxt;
    end
  end

  // The winner's address reaches the RAM in the grant cycle and is held through the response.
  assign mem_addr  = addr_nxt;
  assign mem_wren  = (state_q == WR_COMMIT);
  assign mem_data  = mem_wren ? d_wdata : '0;
  assign i_ack     = (state_q == RD_RESP) && (gnt_q == GNT_I);
  assign d_ack     = ((state_q == RD_RESP) && (gnt_q == GNT_D)) || mem_wren;
  assign i_rdata   = i_ack ? mem_q : '0;
  assign d_rdata   = ((state_q == RD_RESP) && (gnt_q == GNT_D)) ? mem_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and an ack scoreboard.
module tb_mem_arbiter;
  import kanade_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [29:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [29:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_wren;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_q;
  arb_state_t  dbg_state;

  logic [31:0] ram       [0:255];
  logic [31:0] model_mem [0:255];
  // {is_d_port, check_data, data}
  logic [33:0] exp_q[$];

  int n_tests;
  int n_fail;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_q     (mem_q),
    .dbg_state (dbg_state)
  );

  // clock / RAM model with registered address
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr[7:0]] <= mem_data;
    mem_q <= ram[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic access(input bit port_d, input bit we, input logic [29:0] addr,
                        input logic [31:0] wdata);
    int cyc;
    bit got;
    @(negedge clk);
    if (port_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    exp_q.push_back({port_d, ~we, we ? 32'h0 : model_mem[addr[7:0]]});
    if (we) model_mem[addr[7:0]] = wdata;
    #1;
    chk("grant_addr", 64'(mem_addr), 64'(addr));
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      got = port_d ? d_ack : i_ack;
    end
    chk("ack_seen", 64'(got), 64'd1);
    chk("ack_latency", 64'(cyc), 64'd1);
    if (got) begin
      chk("hold_addr", 64'(mem_addr), 64'(addr));
      chk("wren_in_ack", 64'(mem_wren), 64'(we));
      if (we) chk("wdata", 64'(mem_data), 64'(wdata));
    end
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b0;
    if (we) begin
      @(posedge clk);
      #1;
      chk("wren_one_cycle", 64'(mem_wren), 64'd0);
    end
  endtask

  initial begin
    int n;
    int cyc;
    logic [33:0] e;
    bit pd;

    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 256; k++) begin
      ram[k]       = 32'hC0DE_0000 | k;
      model_mem[k] = 32'hC0DE_0000 | k;
    end

    // scoreboard monitor: pops on every ack
    fork
      forever begin
        @(negedge clk);
        if (rst_n && (i_ack || d_ack)) begin
          chk("double_ack", 64'(i_ack && d_ack), 64'd0);
          chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_port", 64'(d_ack), 64'(e[33]));
            if (e[32]) chk("rdata", 64'(d_ack ? d_rdata : i_rdata), 64'(e[31:0]));
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_ack", 64'(i_ack), 64'd0);
    chk("rst_d_ack", 64'(d_ack), 64'd0);
    chk("rst_wren", 64'(mem_wren), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", 64'(mem_data), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // I-only fetch, then D store/load round trip and a few mixed accesses
    access(1'b0, 1'b0, 30'h10, 32'h0);
    access(1'b1, 1'b1, 30'h20, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 30'h20, 32'h0);
    for (int k = 0; k < 4; k++) begin
      pd = 1'($urandom_range(0, 1));
      access(pd, pd ? 1'($urandom_range(0, 1)) : 1'b0, 30'($urandom_range(0, 255)), $urandom);
    end
    access(1'b0, 1'b0, 30'h3FFF_FFFF, 32'h0);

    // reset in the middle of a store
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h40; d_wdata = 32'h1234_5678;
    @(posedge clk);
    #2;
    chk("wc_state", 64'(dbg_state), 64'(WR_COMMIT));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wren", 64'(mem_wren), 64'd0);
    chk("rst_mid_d_ack", 64'(d_ack), 64'd0);
    chk("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_no_commit", 64'(ram[8'h40]), 64'(model_mem[8'h40]));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_addr", 64'(mem_addr), 64'd0);
    chk("post_rst_data", 64'(mem_data), 64'd0);
    chk("post_rst_acks", 64'({i_ack, d_ack, mem_wren}), 64'd0);

    // contention with both requests held back-to-back
    @(negedge clk);
    i_req = 1'b1; i_addr = 30'h50;
    d_req = 1'b1; d_we = 1'b0; d_addr = 30'h60;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
      pd = (k % 2 == 0);
`else
      pd = (k % 5 != 4);
`endif
      exp_q.push_back({pd, 1'b1, pd ? model_mem[8'h60] : model_mem[8'h50]});
    end
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) n++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("contention_acks", 64'(n), 64'd10);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    // idle
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("idle_outs", 64'({i_ack, d_ack, mem_wren}), 64'd0);
      chk("idle_state", 64'(dbg_state), 64'(IDLE));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
